// File: rtl/toy_trap_ctrl_pkg.sv
// Shared constants for the trap controller: CSR addresses, status bit positions and FSM states.
package toy_trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_DCSR    = 12'h7B0;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int DCSR_STEP    = 2;

    typedef enum logic [1:0] {
        TRAP_IDLE     = 2'd0,
        TRAP_FLUSH    = 2'd1,
        TRAP_REDIRECT = 2'd2
    } trap_state_e;

endpackage

// File: rtl/toy_trap_csr_file.sv
// Machine trap CSRs with trap/mret capture priority over software writes.
// TOY_TRAP_VECTORED_EN keeps the mtvec mode bits; otherwise they read as zero.
module toy_trap_csr_file
    import toy_trap_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] MTVEC_RESET = 32'h0000_0100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csr_wr_en,
    input  logic [11:0]           csr_wr_addr,
    input  logic [ADDR_WIDTH-1:0] csr_wr_data,
    input  logic [11:0]           csr_rd_addr,
    output logic [ADDR_WIDTH-1:0] csr_rd_data,
    input  logic                  trap_take,
    input  logic [ADDR_WIDTH-1:0] trap_pc,
    input  logic [31:0]           trap_cause,
    input  logic [ADDR_WIDTH-1:0] trap_extra_info,
    input  logic                  mret_take,
    output logic [ADDR_WIDTH-1:0] mtvec,
    output logic [ADDR_WIDTH-1:0] mepc,
    output logic                  mie,
    output logic                  dcsr_step
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

`ifdef TOY_TRAP_VECTORED_EN
    localparam logic [ADDR_WIDTH-1:0] MTVEC_MASK = '1;
`else
    localparam logic [ADDR_WIDTH-1:0] MTVEC_MASK = ALIGN_MASK;
`endif

    logic                  mpie;
    logic [ADDR_WIDTH-1:0] mcause;
    logic [ADDR_WIDTH-1:0] mtval;

    // Software writes land first; a trap or mret in the same cycle then overrides the status/capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mie       <= 1'b0;
            mpie      <= 1'b0;
            mepc      <= '0;
            mcause    <= '0;
            mtval     <= '0;
            mtvec     <= MTVEC_RESET & MTVEC_MASK;
            dcsr_step <= 1'b0;
        end else begin
            if (csr_wr_en) begin
                case (csr_wr_addr)
                    CSR_MSTATUS: begin
                        mie  <= csr_wr_data[MSTATUS_MIE];
                        mpie <= csr_wr_data[MSTATUS_MPIE];
                    end
                    CSR_MTVEC:  mtvec     <= csr_wr_data & MTVEC_MASK;
                    CSR_MEPC:   mepc      <= csr_wr_data & ALIGN_MASK;
                    CSR_MCAUSE: mcause    <= csr_wr_data;
                    CSR_MTVAL:  mtval     <= csr_wr_data;
                    CSR_DCSR:   dcsr_step <= csr_wr_data[DCSR_STEP];
                    default: ;
                endcase
            end
            if (trap_take) begin
                mepc   <= trap_pc & ALIGN_MASK;
                mcause <= ADDR_WIDTH'(trap_cause);
                mtval  <= trap_extra_info;
                mpie   <= mie;
                mie    <= 1'b0;
            end else if (mret_take) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end
        end
    end

    always_comb begin
        csr_rd_data = '0;
        case (csr_rd_addr)
            CSR_MSTATUS: begin
                csr_rd_data[MSTATUS_MIE]  = mie;
                csr_rd_data[MSTATUS_MPIE] = mpie;
            end
            CSR_MTVEC:  csr_rd_data = mtvec;
            CSR_MEPC:   csr_rd_data = mepc;
            CSR_MCAUSE: csr_rd_data = mcause;
            CSR_MTVAL:  csr_rd_data = mtval;
            CSR_DCSR:   csr_rd_data[DCSR_STEP] = dcsr_step;
            default: ;
        endcase
    end

endmodule

// File: rtl/toy_trap_ctrl.sv
// Trap receive FSM: accept trap/mret, flush for FLUSH_CYCLES, then redirect fetch.
// TOY_TRAP_VECTORED_EN enables vectored interrupt targets from mtvec mode 1.
module toy_trap_ctrl
    import toy_trap_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    FLUSH_CYCLES = 2,
    parameter logic [ADDR_WIDTH-1:0] MTVEC_RESET  = 32'h0000_0100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trap_vld,
    input  logic [ADDR_WIDTH-1:0] trap_pc,
    input  logic [31:0]           trap_cause,
    input  logic [ADDR_WIDTH-1:0] trap_extra_info,
    output logic                  trap_rdy,
    output logic                  trap_step_en,
    input  logic                  mret_vld,
    output logic                  mret_rdy,
    input  logic                  csr_wr_en,
    input  logic [11:0]           csr_wr_addr,
    input  logic [ADDR_WIDTH-1:0] csr_wr_data,
    input  logic [11:0]           csr_rd_addr,
    output logic [ADDR_WIDTH-1:0] csr_rd_data,
    output logic                  flush,
    output logic                  redirect_vld,
    input  logic                  redirect_rdy,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  irq_global_en
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    trap_state_e           state;
    logic [CNT_W-1:0]      flush_cnt;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] trap_target;
    logic [ADDR_WIDTH-1:0] mtvec;
    logic [ADDR_WIDTH-1:0] mepc;
    logic                  dcsr_step;
    logic                  trap_take;
    logic                  mret_take;

    assign trap_take = (state == TRAP_IDLE) && trap_vld;
    assign mret_take = (state == TRAP_IDLE) && mret_vld && !trap_vld;

    toy_trap_csr_file #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .MTVEC_RESET (MTVEC_RESET)
    ) u_csr (
        .clk             (clk),
        .rst             (rst),
        .csr_wr_en       (csr_wr_en),
        .csr_wr_addr     (csr_wr_addr),
        .csr_wr_data     (csr_wr_data),
        .csr_rd_addr     (csr_rd_addr),
        .csr_rd_data     (csr_rd_data),
        .trap_take       (trap_take),
        .trap_pc         (trap_pc),
        .trap_cause      (trap_cause),
        .trap_extra_info (trap_extra_info),
        .mret_take       (mret_take),
        .mtvec           (mtvec),
        .mepc            (mepc),
        .mie             (irq_global_en),
        .dcsr_step       (dcsr_step)
    );

    always_comb begin
        trap_target = mtvec & ~ADDR_WIDTH'(3);
`ifdef TOY_TRAP_VECTORED_EN
        if (mtvec[1:0] == 2'b01 && trap_cause[31])
            trap_target = (mtvec & ~ADDR_WIDTH'(3)) + ADDR_WIDTH'({trap_cause[30:0], 2'b00});
`endif
    end

    // Target is latched at accept so later CSR writes cannot move an in-flight redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= TRAP_IDLE;
            flush_cnt <= '0;
            target    <= '0;
        end else begin
            case (state)
                TRAP_IDLE: begin
                    if (trap_take) begin
                        target    <= trap_target;
                        flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
                        state     <= TRAP_FLUSH;
                    end else if (mret_take) begin
                        target    <= mepc;
                        flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
                        state     <= TRAP_FLUSH;
                    end
                end
                TRAP_FLUSH: begin
                    if (flush_cnt == '0)
                        state <= TRAP_REDIRECT;
                    else
                        flush_cnt <= flush_cnt - 1'b1;
                end
                TRAP_REDIRECT: begin
                    if (redirect_rdy)
                        state <= TRAP_IDLE;
                end
                default: state <= TRAP_IDLE;
            endcase
        end
    end

    assign trap_rdy     = (state == TRAP_IDLE);
    assign mret_rdy     = (state == TRAP_IDLE) && !trap_vld;
    assign flush        = (state == TRAP_FLUSH);
    assign redirect_vld = (state == TRAP_REDIRECT);
    assign redirect_pc  = (state == TRAP_REDIRECT) ? target : '0;
    assign trap_step_en = dcsr_step && (state == TRAP_IDLE);

endmodule

// File: tb/tb_toy_trap_ctrl.sv
// Directed self-checking bench for toy_trap_ctrl (default FLUSH_CYCLES=2, mtvec reset 0x100).
// The vectored section follows TOY_TRAP_VECTORED_EN when the bench is compiled with it.
module tb_toy_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_vld;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic [31:0] trap_extra_info;
    logic        trap_rdy;
    logic        trap_step_en;
    logic        mret_vld;
    logic        mret_rdy;
    logic        csr_wr_en;
    logic [11:0] csr_wr_addr;
    logic [31:0] csr_wr_data;
    logic [11:0] csr_rd_addr;
    logic [31:0] csr_rd_data;
    logic        flush;
    logic        redirect_vld;
    logic        redirect_rdy;
    logic [31:0] redirect_pc;
    logic        irq_global_en;

    int checks = 0;
    int errors = 0;

    toy_trap_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .trap_vld        (trap_vld),
        .trap_pc         (trap_pc),
        .trap_cause      (trap_cause),
        .trap_extra_info (trap_extra_info),
        .trap_rdy        (trap_rdy),
        .trap_step_en    (trap_step_en),
        .mret_vld        (mret_vld),
        .mret_rdy        (mret_rdy),
        .csr_wr_en       (csr_wr_en),
        .csr_wr_addr     (csr_wr_addr),
        .csr_wr_data     (csr_wr_data),
        .csr_rd_addr     (csr_rd_addr),
        .csr_rd_data     (csr_rd_data),
        .flush           (flush),
        .redirect_vld    (redirect_vld),
        .redirect_rdy    (redirect_rdy),
        .redirect_pc     (redirect_pc),
        .irq_global_en   (irq_global_en)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkCsr(input string tag, input logic [11:0] addr, input logic [31:0] expected);
        csr_rd_addr = addr;
        #1;
        checkOutput(tag, csr_rd_data, expected);
    endtask

    task automatic applyStimulus(input logic [11:0] addr, input logic [31:0] data);
        csr_wr_en   = 1'b1;
        csr_wr_addr = addr;
        csr_wr_data = data;
        tick();
        csr_wr_en   = 1'b0;
    endtask

    task automatic raiseTrap(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] info);
        trap_vld        = 1'b1;
        trap_pc         = pc;
        trap_cause      = cause;
        trap_extra_info = info;
    endtask

    logic [31:0] mtvec_wr_expect;
    logic [31:0] vec_irq_expect;

    initial begin
`ifdef TOY_TRAP_VECTORED_EN
        mtvec_wr_expect = 32'h0000_0103;
        vec_irq_expect  = 32'h0000_011C;
`else
        mtvec_wr_expect = 32'h0000_0100;
        vec_irq_expect  = 32'h0000_0100;
`endif
        rst = 1'b1;
        trap_vld = 1'b0; trap_pc = '0; trap_cause = '0; trap_extra_info = '0;
        mret_vld = 1'b0; redirect_rdy = 1'b0;
        csr_wr_en = 1'b0; csr_wr_addr = '0; csr_wr_data = '0; csr_rd_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] reset values");
        checkOutput("rst_trap_rdy", {31'd0, trap_rdy}, 32'd1);
        checkOutput("rst_mret_rdy", {31'd0, mret_rdy}, 32'd1);
        checkOutput("rst_flush", {31'd0, flush}, 32'd0);
        checkOutput("rst_redirect_vld", {31'd0, redirect_vld}, 32'd0);
        checkOutput("rst_redirect_pc", redirect_pc, 32'd0);
        checkOutput("rst_step_en", {31'd0, trap_step_en}, 32'd0);
        checkOutput("rst_irq_en", {31'd0, irq_global_en}, 32'd0);
        checkCsr("rst_mtvec", 12'h305, 32'h0000_0100);
        checkCsr("rst_mstatus", 12'h300, 32'h0);

        $display("[TB] CSR write masking");
        applyStimulus(12'h300, 32'hFFFF_FFFF);
        checkCsr("mstatus_mask", 12'h300, 32'h0000_0088);
        applyStimulus(12'h300, 32'h0000_0008);
        checkCsr("mstatus_mie", 12'h300, 32'h0000_0008);
        checkOutput("irq_en_set", {31'd0, irq_global_en}, 32'd1);
        applyStimulus(12'h341, 32'h0000_1237);
        checkCsr("mepc_align", 12'h341, 32'h0000_1234);
        applyStimulus(12'h305, 32'h0000_0103);
        checkCsr("mtvec_mode", 12'h305, mtvec_wr_expect);
        applyStimulus(12'h305, 32'h0000_0100);
        applyStimulus(12'h7B0, 32'hFFFF_FFFF);
        checkCsr("dcsr_mask", 12'h7B0, 32'h0000_0004);
        checkOutput("step_en_idle", {31'd0, trap_step_en}, 32'd1);
        applyStimulus(12'h7B0, 32'h0);
        checkOutput("step_en_clr", {31'd0, trap_step_en}, 32'd0);
        checkCsr("unmapped", 12'h123, 32'h0);

        $display("[TB] exception trap");
        raiseTrap(32'h0000_2002, 32'h0000_0002, 32'h0000_DEAD);
        #1;
        checkOutput("exc_mret_rdy_blocked", {31'd0, mret_rdy}, 32'd0);
        tick();
        trap_vld = 1'b0;
        checkOutput("exc_trap_rdy_drop", {31'd0, trap_rdy}, 32'd0);
        checkOutput("exc_flush1", {31'd0, flush}, 32'd1);
        checkCsr("exc_mepc", 12'h341, 32'h0000_2000);
        checkCsr("exc_mcause", 12'h342, 32'h0000_0002);
        checkCsr("exc_mtval", 12'h343, 32'h0000_DEAD);
        checkCsr("exc_mstatus", 12'h300, 32'h0000_0080);
        checkOutput("exc_irq_en", {31'd0, irq_global_en}, 32'd0);
        tick();
        checkOutput("exc_flush2", {31'd0, flush}, 32'd1);
        checkOutput("exc_no_redirect_yet", {31'd0, redirect_vld}, 32'd0);
        tick();
        checkOutput("exc_flush_done", {31'd0, flush}, 32'd0);
        checkOutput("exc_redirect_vld", {31'd0, redirect_vld}, 32'd1);
        checkOutput("exc_redirect_pc", redirect_pc, 32'h0000_0100);
        redirect_rdy = 1'b1;
        tick();
        redirect_rdy = 1'b0;
        checkOutput("exc_back_idle", {31'd0, trap_rdy}, 32'd1);
        checkOutput("exc_redirect_clr", {31'd0, redirect_vld}, 32'd0);

        $display("[TB] mret");
        mret_vld = 1'b1;
        #1;
        checkOutput("mret_rdy", {31'd0, mret_rdy}, 32'd1);
        tick();
        mret_vld = 1'b0;
        checkOutput("mret_flush1", {31'd0, flush}, 32'd1);
        checkCsr("mret_mstatus", 12'h300, 32'h0000_0088);
        checkOutput("mret_irq_en", {31'd0, irq_global_en}, 32'd1);
        tick();
        checkOutput("mret_flush2", {31'd0, flush}, 32'd1);
        tick();
        checkOutput("mret_redirect_vld", {31'd0, redirect_vld}, 32'd1);
        checkOutput("mret_redirect_pc", redirect_pc, 32'h0000_2000);
        redirect_rdy = 1'b1;
        tick();
        redirect_rdy = 1'b0;

        $display("[TB] simultaneous trap, mret and mepc write");
        raiseTrap(32'h0000_3000, 32'h0000_000B, 32'h0000_0077);
        mret_vld = 1'b1;
        csr_wr_en = 1'b1; csr_wr_addr = 12'h341; csr_wr_data = 32'h0000_5000;
        #1;
        checkOutput("sim_mret_rdy", {31'd0, mret_rdy}, 32'd0);
        tick();
        csr_wr_en = 1'b0; mret_vld = 1'b0;
        checkCsr("sim_mepc", 12'h341, 32'h0000_3000);
        checkCsr("sim_mcause", 12'h342, 32'h0000_000B);
        checkCsr("sim_mstatus", 12'h300, 32'h0000_0080);
        trap_pc = 32'h0000_4000;
        tick();
        tick();
        checkOutput("sim_redirect_pc", redirect_pc, 32'h0000_0100);

        $display("[TB] redirect backpressure");
        applyStimulus(12'h305, 32'h0000_0200);
        for (int i = 0; i < 4; i++) begin
            checkOutput("bp_redirect_vld", {31'd0, redirect_vld}, 32'd1);
            checkOutput("bp_redirect_pc", redirect_pc, 32'h0000_0100);
            checkOutput("bp_trap_rdy", {31'd0, trap_rdy}, 32'd0);
            tick();
        end
        checkOutput("bp_redirect_pc_last", redirect_pc, 32'h0000_0100);
        checkCsr("bp_mepc_kept", 12'h341, 32'h0000_3000);
        trap_vld = 1'b0;
        redirect_rdy = 1'b1;
        tick();
        redirect_rdy = 1'b0;
        checkOutput("bp_idle", {31'd0, trap_rdy}, 32'd1);
        checkCsr("bp_mtvec", 12'h305, 32'h0000_0200);
        applyStimulus(12'h305, 32'h0000_0100);

        $display("[TB] single step and reset during flush");
        applyStimulus(12'h7B0, 32'h0000_0004);
        checkOutput("step_idle", {31'd0, trap_step_en}, 32'd1);
        raiseTrap(32'h0000_6000, 32'h0000_0003, 32'h0);
        tick();
        trap_vld = 1'b0;
        checkOutput("step_flush", {31'd0, trap_step_en}, 32'd0);
        checkOutput("step_in_flush", {31'd0, flush}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_rst_trap_rdy", {31'd0, trap_rdy}, 32'd1);
        checkOutput("mid_rst_flush", {31'd0, flush}, 32'd0);
        checkOutput("mid_rst_redirect", {31'd0, redirect_vld}, 32'd0);
        checkOutput("mid_rst_step_en", {31'd0, trap_step_en}, 32'd0);
        checkOutput("mid_rst_irq_en", {31'd0, irq_global_en}, 32'd0);
        checkCsr("mid_rst_mepc", 12'h341, 32'h0);
        tick();
        tick();
        checkOutput("mid_rst_no_redirect", {31'd0, redirect_vld}, 32'd0);

        $display("[TB] vectored interrupt targets");
        applyStimulus(12'h305, 32'h0000_0101);
        raiseTrap(32'h0000_7000, 32'h8000_0007, 32'h0);
        tick();
        trap_vld = 1'b0;
        tick();
        tick();
        checkOutput("vec_irq_vld", {31'd0, redirect_vld}, 32'd1);
        checkOutput("vec_irq_pc", redirect_pc, vec_irq_expect);
        redirect_rdy = 1'b1;
        tick();
        redirect_rdy = 1'b0;
        raiseTrap(32'h0000_7100, 32'h0000_0005, 32'h0);
        tick();
        trap_vld = 1'b0;
        tick();
        tick();
        checkOutput("vec_exc_pc", redirect_pc, 32'h0000_0100);
        redirect_rdy = 1'b1;
        tick();
        redirect_rdy = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
